// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with four-word lines filled over a counted-latency
// memory read port. Define ICACHE_STATS_EN to build the saturating hit/miss counters.
`timescale 1ns / 1ps

`ifndef OPCODE_NOP
`define OPCODE_NOP 4'hF
`endif

module icache_direct #(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned NUM_LINES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic [15:0] cpu_address,
    output logic [15:0] cpu_data,
    output logic        cpu_ready,
    input  logic        invalidate,
    output logic        mem_readM,
    output logic        mem_writeM,
    output logic [15:0] mem_address,
    input  logic [15:0] mem_data,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int unsigned IdxW = $clog2(NUM_LINES);
    localparam int unsigned TagW = 14 - IdxW;
    localparam int unsigned PhW  = $clog2(LATENCY + 1);
    localparam logic [PhW-1:0] PhSample = PhW'(LATENCY);
    localparam logic [15:0]    NopWord  = {`OPCODE_NOP, 12'b0};

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e          state_q, state_d;
    logic [1:0]      w_q, w_d;
    logic [PhW-1:0]  p_q, p_d;
    logic [13:0]     base_q, base_d;
    logic            sample;

    logic [NUM_LINES-1:0] valid_q;
    logic [TagW-1:0]      tag_q  [NUM_LINES];
    logic [15:0]          data_q [NUM_LINES][4];

    logic [IdxW-1:0] idx, fill_idx;
    logic [TagW-1:0] tag, fill_tag;
    logic [1:0]      off;
    logic            lookup_hit;

    assign idx        = cpu_address[2 +: IdxW];
    assign tag        = cpu_address[15 -: TagW];
    assign off        = cpu_address[1:0];
    assign fill_idx   = base_q[IdxW-1:0];
    assign fill_tag   = base_q[13 -: TagW];
    assign lookup_hit = cpu_read && valid_q[idx] && (tag_q[idx] == tag);
    assign mem_writeM = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            w_q     <= '0;
            p_q     <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            p_q     <= p_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        p_d         = p_q;
        base_d      = base_q;
        cpu_ready   = 1'b0;
        cpu_data    = NopWord;
        mem_readM   = 1'b0;
        mem_address = '0;
        sample      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_read) begin
                    if (lookup_hit) begin
                        cpu_ready = 1'b1;
                        cpu_data  = data_q[idx][off];
                    end else begin
                        base_d  = cpu_address[15:2];
                        w_d     = '0;
                        p_d     = '0;
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                mem_address = {base_q, w_q};
                // Strobe for LATENCY cycles, then one quiet cycle in which the word is valid.
                if (p_q == PhSample) begin
                    sample = 1'b1;
                    p_d    = '0;
                    w_d    = w_q + 2'd1;
                    if (w_q == 2'd3) begin
                        state_d = StIdle;
                    end
                end else begin
                    mem_readM = 1'b1;
                    p_d       = p_q + PhW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(NUM_LINES); i++) begin
                tag_q[i] <= '0;
                for (int j = 0; j < 4; j++) begin
                    data_q[i][j] <= '0;
                end
            end
        end else begin
            if (invalidate) begin
                valid_q <= '0;
            end
            if (sample) begin
                data_q[fill_idx][w_q] <= mem_data;
                // Installing after the clear lets a fill finish valid despite an invalidate.
                if (w_q == 2'd3) begin
                    tag_q[fill_idx]   <= fill_tag;
                    valid_q[fill_idx] <= 1'b1;
                end
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_q, miss_q;
    logic        miss;

    assign miss = (state_q == StIdle) && cpu_read && !lookup_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (cpu_ready && (hit_q != 16'hFFFF)) begin
                hit_q <= hit_q + 16'd1;
            end
            if (miss && (miss_q != 16'hFFFF)) begin
                miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
